alu_control_seq: RTL and testbench

ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

---
 rtl/alu_ctrl_pkg.sv | 66 ++++++
 rtl/alu_ctrl_decode.sv | 58 +++++
 rtl/alu_control_seq.sv | 97 +++++++++
 tb/tb_alu_control_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: ALUop classes, R-type funct
// codes, ALUcontrol codes, mult/div selects, FSM states and the decode bundle.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_RTYPE = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_SLT   = 3'b101;
    localparam logic [2:0] OP_LUI   = 3'b110;
    localparam logic [2:0] OP_ILL   = 3'b111;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SLL  = 4'b1000;
    localparam logic [3:0] C_SRL  = 4'b1001;
    localparam logic [3:0] C_SRA  = 4'b1010;
    localparam logic [3:0] C_LUI  = 4'b1011;
    localparam logic [3:0] C_NOR  = 4'b1100;
    localparam logic [3:0] C_MFHI = 4'b1101;
    localparam logic [3:0] C_MFLO = 4'b1110;
    localparam logic [3:0] C_NOP  = 4'b1111;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MD_RUN  = 2'd1,
        S_MD_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] code;
        logic       is_md;
        logic [1:0] md_sel;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ALUop/funct to ALU control decode.
// Latency: purely combinational, no state.
// Backpressure: none; the sequencer decides whether the result is accepted.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OPW = 3
) (
    input  logic [OPW-1:0] ALUop,
    input  logic [5:0]     funct,
    output dec_t           dec
);

    logic [2:0] op3;
    logic       op_hi;

    assign op3   = ALUop[2:0];
    assign op_hi = (ALUop >> 3) != '0;

    always_comb begin
        dec = '{code: C_NOP, is_md: 1'b0, md_sel: MD_MULT, illegal: 1'b0};
        case (op3)
            OP_ADD: dec.code = C_ADD;
            OP_SUB: dec.code = C_SUB;
            OP_AND: dec.code = C_AND;
            OP_OR:  dec.code = C_OR;
            OP_SLT: dec.code = C_SLT;
            OP_LUI: dec.code = C_LUI;
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: dec.code = C_ADD;
                    F_SUB, F_SUBU: dec.code = C_SUB;
                    F_AND:   dec.code = C_AND;
                    F_OR:    dec.code = C_OR;
                    F_XOR:   dec.code = C_XOR;
                    F_NOR:   dec.code = C_NOR;
                    F_SLT:   dec.code = C_SLT;
                    F_SLL:   dec.code = C_SLL;
                    F_SRL:   dec.code = C_SRL;
                    F_SRA:   dec.code = C_SRA;
                    F_MFHI:  dec.code = C_MFHI;
                    F_MFLO:  dec.code = C_MFLO;
                    F_MULT:  begin dec.is_md = 1'b1; dec.md_sel = MD_MULT;  end
                    F_MULTU: begin dec.is_md = 1'b1; dec.md_sel = MD_MULTU; end
                    F_DIV:   begin dec.is_md = 1'b1; dec.md_sel = MD_DIV;   end
                    F_DIVU:  begin dec.is_md = 1'b1; dec.md_sel = MD_DIVU;  end
                    default: dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
        // ALUop values beyond the 3-bit map are never decodable
        if (op_hi) begin
            dec = '{code: C_NOP, is_md: 1'b0, md_sel: MD_MULT, illegal: 1'b1};
        end
    end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control sequencer: registered decode plus mult/div busy sequencing.
// Latency: 1 cycle for single-cycle ops; mult/div holds busy for MD_LAT cycles then pulses done.
// Backpressure: valid_in is dropped while busy; upstream must hold until done.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int MD_LAT = 32,
    parameter int OPW    = 3,
    parameter int CTLW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [OPW-1:0]  ALUop,
    input  logic [5:0]      funct,
    output logic [CTLW-1:0] ALUcontrol,
    output logic            ctrl_valid,
    output logic            illegal,
    output logic            busy,
    output logic            md_start,
    output logic [1:0]      md_sel,
    output logic            done
);

    localparam logic [7:0]      CNT_INIT = 8'(MD_LAT - 1);
    localparam logic [CTLW-1:0] CTL_NOP  = CTLW'(C_NOP);

    dec_t            dec;
    state_t          state, state_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic [CTLW-1:0] ctl_nxt;
    logic            ctrl_valid_nxt, illegal_nxt, md_start_nxt;
    logic [1:0]      md_sel_nxt;

    alu_ctrl_decode #(.OPW(OPW)) u_decode (
        .ALUop (ALUop),
        .funct (funct),
        .dec   (dec)
    );

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        ctl_nxt        = ALUcontrol;
        md_sel_nxt     = md_sel;
        ctrl_valid_nxt = 1'b0;
        illegal_nxt    = 1'b0;
        md_start_nxt   = 1'b0;
        case (state)
            S_MD_RUN: begin
                if (cnt == 8'd0) state_nxt = S_MD_DONE;
                else             cnt_nxt   = cnt - 8'd1;
            end
            default: begin
                // IDLE and MD_DONE both accept a new op
                state_nxt = S_IDLE;
                if (valid_in) begin
                    if (dec.is_md) begin
                        state_nxt    = S_MD_RUN;
                        cnt_nxt      = CNT_INIT;
                        md_start_nxt = 1'b1;
                        md_sel_nxt   = dec.md_sel;
                        ctl_nxt      = CTL_NOP;
                    end else begin
                        ctl_nxt        = CTLW'(dec.code);
                        ctrl_valid_nxt = 1'b1;
                        illegal_nxt    = dec.illegal;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            ALUcontrol <= CTL_NOP;
            md_sel     <= MD_MULT;
            ctrl_valid <= 1'b0;
            illegal    <= 1'b0;
            md_start   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ALUcontrol <= ctl_nxt;
            md_sel     <= md_sel_nxt;
            ctrl_valid <= ctrl_valid_nxt;
            illegal    <= illegal_nxt;
            md_start   <= md_start_nxt;
        end
    end

    assign busy = (state == S_MD_RUN);
    assign done = (state == S_MD_DONE);

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: two instances (MD_LAT=4 and MD_LAT=1) share stimulus;
// directed table and sequences, then random traffic against a cycle-count model.
module tb_alu_control_seq;

    typedef struct {
        int       busy_left;
        bit       done;
        bit       cv;
        bit       ill;
        bit       start;
        bit [1:0] sel;
        bit [3:0] ctl;
    } mdl_t;

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] ctl;
        logic       ill;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [2:0] ALUop = 3'd0;
    logic [5:0] funct = 6'd0;

    logic [3:0] a_ctl, b_ctl;
    logic       a_cv, a_ill, a_busy, a_start, a_done;
    logic       b_cv, b_ill, b_busy, b_start, b_done;
    logic [1:0] a_sel, b_sel;

    int   checks = 0;
    int   errors = 0;
    mdl_t m4, m1;
    bit [3:0] opmap [int];
    bit [3:0] rmap [int];
    bit [5:0] flist [18];
    vec_t     vt [23];

    always #5 clk = ~clk;

    alu_control_seq #(.MD_LAT(4), .OPW(3), .CTLW(4)) dut4 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ALUop(ALUop), .funct(funct),
        .ALUcontrol(a_ctl), .ctrl_valid(a_cv), .illegal(a_ill), .busy(a_busy),
        .md_start(a_start), .md_sel(a_sel), .done(a_done)
    );

    alu_control_seq #(.MD_LAT(1), .OPW(3), .CTLW(4)) dut1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ALUop(ALUop), .funct(funct),
        .ALUcontrol(b_ctl), .ctrl_valid(b_cv), .illegal(b_ill), .busy(b_busy),
        .md_start(b_start), .md_sel(b_sel), .done(b_done)
    );

    function automatic void ref_dec(input bit [2:0] op, input bit [5:0] fn,
                                    output bit [3:0] c, output bit md,
                                    output bit [1:0] sl, output bit il);
        c = 4'hF; md = 1'b0; sl = 2'd0; il = 1'b0;
        if (op == 3'd2) begin
            if (fn >= 6'd24 && fn <= 6'd27) begin
                md = 1'b1;
                sl = 2'(fn - 6'd24);
            end else if (rmap.exists(int'(fn))) c = rmap[int'(fn)];
            else il = 1'b1;
        end else if (op == 3'd7) il = 1'b1;
        else c = opmap[int'(op)];
    endfunction

    function automatic mdl_t mstep(mdl_t s, int lat, bit r, bit v, bit [2:0] op, bit [5:0] fn);
        mdl_t n = s;
        bit [3:0] c;
        bit md, il;
        bit [1:0] sl;
        n.cv = 1'b0; n.ill = 1'b0; n.start = 1'b0; n.done = 1'b0;
        if (r) begin
            n.busy_left = 0; n.ctl = 4'hF; n.sel = 2'd0;
            return n;
        end
        if (s.busy_left > 0) begin
            n.busy_left = s.busy_left - 1;
            n.done = (n.busy_left == 0);
        end else if (v) begin
            ref_dec(op, fn, c, md, sl, il);
            if (md) begin
                n.busy_left = lat; n.start = 1'b1; n.sel = sl; n.ctl = 4'hF;
            end else begin
                n.ctl = c; n.cv = 1'b1; n.ill = il;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m4 = mstep(m4, 4, rst, valid_in, ALUop, funct);
        m1 = mstep(m1, 1, rst, valid_in, ALUop, funct);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input string tag, input logic [3:0] ctl, input logic cv,
                           input logic il, input logic bsy, input logic st,
                           input logic [1:0] sl, input logic dn, input mdl_t e);
        chk({tag, ".ctl"}, 32'(ctl), 32'(e.ctl));
        chk({tag, ".cv"}, 32'(cv), 32'(e.cv));
        chk({tag, ".ill"}, 32'(il), 32'(e.ill));
        chk({tag, ".busy"}, 32'(bsy), 32'(e.busy_left > 0));
        chk({tag, ".start"}, 32'(st), 32'(e.start));
        chk({tag, ".sel"}, 32'(sl), 32'(e.sel));
        chk({tag, ".done"}, 32'(dn), 32'(e.done));
    endtask

    task automatic drive(input bit r, input bit v, input bit [2:0] op, input bit [5:0] fn);
        rst = r; valid_in = v; ALUop = op; funct = fn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        opmap[0] = 4'b0010; opmap[1] = 4'b0110; opmap[3] = 4'b0000;
        opmap[4] = 4'b0001; opmap[5] = 4'b0111; opmap[6] = 4'b1011;
        rmap[32] = 4'b0010; rmap[33] = 4'b0010; rmap[34] = 4'b0110; rmap[35] = 4'b0110;
        rmap[36] = 4'b0000; rmap[37] = 4'b0001; rmap[38] = 4'b0011; rmap[39] = 4'b1100;
        rmap[42] = 4'b0111; rmap[0] = 4'b1000; rmap[2] = 4'b1001; rmap[3] = 4'b1010;
        rmap[16] = 4'b1101; rmap[18] = 4'b1110;
        flist = '{6'd24, 6'd25, 6'd26, 6'd27, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36,
                  6'd37, 6'd38, 6'd39, 6'd42, 6'd0, 6'd2, 6'd3, 6'd16, 6'd18};

        vt[0]  = '{3'b010, 6'b100010, 4'b0110, 1'b0};
        vt[1]  = '{3'b000, 6'b000000, 4'b0010, 1'b0};
        vt[2]  = '{3'b001, 6'b101010, 4'b0110, 1'b0};
        vt[3]  = '{3'b011, 6'b000000, 4'b0000, 1'b0};
        vt[4]  = '{3'b100, 6'b000000, 4'b0001, 1'b0};
        vt[5]  = '{3'b101, 6'b000000, 4'b0111, 1'b0};
        vt[6]  = '{3'b110, 6'b000000, 4'b1011, 1'b0};
        vt[7]  = '{3'b111, 6'b100000, 4'b1111, 1'b1};
        vt[8]  = '{3'b010, 6'b111111, 4'b1111, 1'b1};
        vt[9]  = '{3'b010, 6'b100000, 4'b0010, 1'b0};
        vt[10] = '{3'b010, 6'b100001, 4'b0010, 1'b0};
        vt[11] = '{3'b010, 6'b100011, 4'b0110, 1'b0};
        vt[12] = '{3'b010, 6'b100100, 4'b0000, 1'b0};
        vt[13] = '{3'b010, 6'b100101, 4'b0001, 1'b0};
        vt[14] = '{3'b010, 6'b100110, 4'b0011, 1'b0};
        vt[15] = '{3'b010, 6'b100111, 4'b1100, 1'b0};
        vt[16] = '{3'b010, 6'b101010, 4'b0111, 1'b0};
        vt[17] = '{3'b010, 6'b000000, 4'b1000, 1'b0};
        vt[18] = '{3'b010, 6'b000010, 4'b1001, 1'b0};
        vt[19] = '{3'b010, 6'b000011, 4'b1010, 1'b0};
        vt[20] = '{3'b010, 6'b010000, 4'b1101, 1'b0};
        vt[21] = '{3'b010, 6'b010010, 4'b1110, 1'b0};
        vt[22] = '{3'b010, 6'b000001, 4'b1111, 1'b1};

        // reset with a valid op present: it must be discarded
        drive(1, 1, 3'b000, 6'd0);
        tick();
        tick();
        chk("rst.ctl", 32'(a_ctl), 32'hF);
        chk("rst.cv", 32'(a_cv), 0);
        chk("rst.ill", 32'(a_ill), 0);
        chk("rst.busy", 32'(a_busy), 0);
        chk("rst.start", 32'(a_start), 0);
        chk("rst.sel", 32'(a_sel), 0);
        chk("rst.done", 32'(a_done), 0);

        // back-to-back single-cycle decodes
        for (int i = 0; i < 23; i++) begin
            drive(0, 1, vt[i].op, vt[i].fn);
            tick();
            chk($sformatf("vec%0d.ctl", i), 32'(a_ctl), 32'(vt[i].ctl));
            chk($sformatf("vec%0d.cv", i), 32'(a_cv), 1);
            chk($sformatf("vec%0d.ill", i), 32'(a_ill), 32'(vt[i].ill));
            chk($sformatf("vec%0d.start", i), 32'(a_start), 0);
        end
        drive(0, 0, 3'b000, 6'd0);
        tick();
        chk("idle.cv", 32'(a_cv), 0);
        chk("idle.ill", 32'(a_ill), 0);
        chk("idle.hold", 32'(a_ctl), 32'hF);

        // div on MD_LAT=4, mult held through the run, ADD in the done cycle
        drive(0, 1, 3'b010, 6'b011010);
        tick();
        chk("div.start", 32'(a_start), 1);
        chk("div.sel", 32'(a_sel), 32'b10);
        chk("div.busy", 32'(a_busy), 1);
        chk("div.cv", 32'(a_cv), 0);
        chk("div.ctl", 32'(a_ctl), 32'hF);
        for (int i = 2; i <= 4; i++) begin
            drive(0, 1, 3'b010, 6'b011000);
            tick();
            chk($sformatf("run%0d.busy", i), 32'(a_busy), 1);
            chk($sformatf("run%0d.start", i), 32'(a_start), 0);
            chk($sformatf("run%0d.done", i), 32'(a_done), 0);
            chk($sformatf("run%0d.sel", i), 32'(a_sel), 32'b10);
        end
        drive(0, 1, 3'b010, 6'b011000);
        tick();
        chk("mdd.done", 32'(a_done), 1);
        chk("mdd.busy", 32'(a_busy), 0);
        drive(0, 1, 3'b000, 6'd0);
        tick();
        chk("add.ctl", 32'(a_ctl), 32'b0010);
        chk("add.cv", 32'(a_cv), 1);
        chk("add.done", 32'(a_done), 0);
        chk("add.busy", 32'(a_busy), 0);
        chk("add.start", 32'(a_start), 0);

        // reset in the 2nd MD_RUN cycle aborts without a done pulse
        drive(0, 1, 3'b010, 6'b011000);
        tick();
        drive(0, 0, 3'b000, 6'd0);
        tick();
        chk("abort.busy_pre", 32'(a_busy), 1);
        drive(1, 0, 3'b000, 6'd0);
        tick();
        chk("abort.busy", 32'(a_busy), 0);
        chk("abort.ctl", 32'(a_ctl), 32'hF);
        drive(0, 0, 3'b000, 6'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("abort.nodone%0d", i), 32'(a_done), 0);
        end
        drive(0, 1, 3'b000, 6'd0);
        tick();
        chk("abort.add", 32'(a_ctl), 32'b0010);
        chk("abort.cv", 32'(a_cv), 1);

        // divu on MD_LAT=1
        drive(0, 1, 3'b010, 6'b011011);
        tick();
        chk("l1.busy", 32'(b_busy), 1);
        chk("l1.sel", 32'(b_sel), 32'b11);
        chk("l1.start", 32'(b_start), 1);
        chk("l1.done0", 32'(b_done), 0);
        drive(0, 0, 3'b000, 6'd0);
        tick();
        chk("l1.done", 32'(b_done), 1);
        chk("l1.busy2", 32'(b_busy), 0);
        chk("l1.sel2", 32'(b_sel), 32'b11);
        tick();
        chk("l1.done_clr", 32'(b_done), 0);

        // random traffic against the model (resynchronise through reset first)
        drive(1, 0, 3'b000, 6'd0);
        tick();
        for (int i = 0; i < 3000; i++) begin
            bit [2:0] op;
            bit [5:0] fn;
            op = ($urandom_range(0, 2) == 0) ? 3'd2 : 3'($urandom_range(0, 7));
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : flist[$urandom_range(0, 17)];
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7), op, fn);
            tick();
            chk_dut("r4", a_ctl, a_cv, a_ill, a_busy, a_start, a_sel, a_done, m4);
            chk_dut("r1", b_ctl, b_cv, b_ill, b_busy, b_start, b_sel, b_done, m1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
